// File: rtl/me_pkg.sv
// Shared ME_DMT datapath geometry: pixel width, block shape and the derived bus widths.
package me_pkg;

    localparam int unsigned PIXEL = 8;
    localparam int unsigned ROWS  = 8;
    localparam int unsigned COLS  = 32;
    localparam int unsigned ROW_W = COLS * PIXEL;
    localparam int unsigned BLK_W = ROWS * COLS * PIXEL;
    localparam int unsigned CNT_W = $clog2(ROWS);

    typedef logic [CNT_W-1:0] row_idx_t;

    localparam row_idx_t LAST_ROW = row_idx_t'(ROWS - 1);

endpackage

// File: rtl/row_pack_bank.sv
// One ROWS x COLS pixel bank: row-indexed write port, all rows visible on a flat read bus.
module row_pack_bank
    import me_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  row_idx_t              wr_row_i,
    input  logic [ROW_W-1:0]      wr_data_i,
    output logic [ROWS*ROW_W-1:0] rd_data_o
);

    logic [ROW_W-1:0] mem_q [ROWS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < ROWS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_row_i] <= wr_data_i;
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_rd
        assign rd_data_o[r*ROW_W +: ROW_W] = mem_q[r];
    end

endmodule

// File: rtl/row_pack.sv
// Row-to-block packer: collects ROWS rows into ping-pong banks and presents each
// finished bank as a column-major block on a valid/ready output.
module row_pack
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROW_W-1:0] row_in,
    input  logic             row_valid,
    input  logic             row_sync,
    output logic             row_ready,
    output logic [BLK_W-1:0] blk_out,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             row_err
);

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    row_idx_t   row_cnt_q, row_cnt_d;
    logic       row_err_q, row_err_d;

    logic       accept;
    logic       complete;
    logic       release_blk;
    row_idx_t   wr_row;

    logic [ROWS*ROW_W-1:0] bank0_rows, bank1_rows, rd_rows;

    assign row_ready   = !full_q[wr_bank_q];
    assign accept      = row_valid && row_ready;
    assign wr_row      = row_sync ? '0 : row_cnt_q;
    // A sync on the last slot restarts the block, so it never completes one.
    assign complete    = accept && !row_sync && (row_cnt_q == LAST_ROW);
    assign blk_valid   = full_q[rd_bank_q];
    assign release_blk = blk_valid && blk_ready;
    assign row_err     = row_err_q;

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        row_cnt_d = row_cnt_q;
        row_err_d = 1'b0;
        if (accept) begin
            row_cnt_d = row_sync ? row_idx_t'(1) : row_cnt_q + 1'b1;
            row_err_d = row_sync && (row_cnt_q != '0);
        end
        // Completion and release always target different banks, so both apply.
        if (complete) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
        end
        if (release_blk) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            row_cnt_q <= '0;
            row_err_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            row_cnt_q <= row_cnt_d;
            row_err_q <= row_err_d;
        end
    end

    row_pack_bank u_bank0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept && !wr_bank_q),
        .wr_row_i  (wr_row),
        .wr_data_i (row_in),
        .rd_data_o (bank0_rows)
    );

    row_pack_bank u_bank1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept && wr_bank_q),
        .wr_row_i  (wr_row),
        .wr_data_i (row_in),
        .rd_data_o (bank1_rows)
    );

    assign rd_rows = rd_bank_q ? bank1_rows : bank0_rows;

    // Row-major bank storage (column 0 in a row's MSBs) to column-major block.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            assign blk_out[(c*ROWS + r)*PIXEL +: PIXEL] =
                rd_rows[r*ROW_W + (COLS - c)*PIXEL - 1 -: PIXEL];
        end
    end

endmodule

// File: tb/tb_row_pack.sv
// Scoreboard bench for row_pack: a row-list reference model queues expected blocks,
// a monitor pops and compares on every output handshake and tracks row_err.
module tb_row_pack;
    import me_pkg::*;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [BLK_W-1:0] blk_t;

    logic             clk = 1'b0;
    logic             rst_n;
    row_t             row_in;
    logic             row_valid;
    logic             row_sync;
    logic             row_ready;
    blk_t             blk_out;
    logic             blk_valid;
    logic             blk_ready;
    logic             row_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_pulses = 0;
    bit err_next = 0;
    bit err_exp = 0;
    bit rand_rdy = 0;

    row_t model_rows[$];
    blk_t exp_q[$];
    int   hs_cyc[$];

    row_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .row_valid (row_valid),
        .row_sync  (row_sync),
        .row_ready (row_ready),
        .blk_out   (blk_out),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .row_err   (row_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input blk_t act, input blk_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int k = 0; k < ROWS*COLS; k++) begin
                if (act[k*PIXEL +: PIXEL] !== exp[k*PIXEL +: PIXEL]) begin
                    $display("FAIL %s: pixel slot %0d got %0h expected %0h", name, k,
                             act[k*PIXEL +: PIXEL], exp[k*PIXEL +: PIXEL]);
                    break;
                end
            end
        end
    endtask

    // Column c of a row is the c-th pixel counting from the MSB end.
    function automatic logic [PIXEL-1:0] pix_of(input row_t row, input int c);
        row_t t;
        t = row >> ((COLS - 1 - c) * PIXEL);
        return t[PIXEL-1:0];
    endfunction

    function automatic blk_t build_block();
        blk_t b;
        b = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                b[(c*ROWS + r)*PIXEL +: PIXEL] = pix_of(model_rows[r], c);
        return b;
    endfunction

    function automatic row_t pat_row(input int r);
        row_t t;
        t = '0;
        for (int c = 0; c < COLS; c++) t = (t << PIXEL) | row_t'(8'(r*COLS + c));
        return t;
    endfunction

    function automatic row_t rnd_row();
        row_t t;
        for (int i = 0; i < ROW_W/32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic model_accept(input row_t d, input bit s);
        if (s) begin
            if (model_rows.size() != 0) err_next = 1;
            model_rows.delete();
        end
        model_rows.push_back(d);
        if (model_rows.size() == ROWS) begin
            exp_q.push_back(build_block());
            model_rows.delete();
        end
    endtask

    // Offer one row; row_ready depends only on state, so it is read before the edge.
    task automatic send_row(input row_t d, input bit s, input int set_rdy);
        bit ok;
        ok = 0;
        @(negedge clk);
        row_in = d;
        row_sync = s;
        row_valid = 1'b1;
        if (set_rdy >= 0) blk_ready = set_rdy[0];
        for (int w = 0; w < 60; w++) begin
            #1;
            if (row_ready) begin
                model_accept(d, s);
                ok = 1;
            end
            @(posedge clk);
            if (ok) break;
            @(negedge clk);
        end
        #1 row_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL row_accept_timeout: row_ready stayed %0b, required 1", row_ready);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                err_exp = 0;
                err_next = 0;
            end else begin
                err_exp = err_next;
                err_next = 0;
                cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_rdy) blk_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: sampled after all negedge-side drive updates have settled.
    initial begin
        blk_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1) begin
                chk("row_err", {31'b0, row_err}, {31'b0, err_exp});
                if (row_err === 1'b1) err_pulses++;
                if (blk_valid === 1'b1 && blk_ready === 1'b1) begin
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL blk_unexpected: blk_valid 1 with no block expected");
                    end else begin
                        e = exp_q.pop_front();
                        chk_blk("blk_out", blk_out, e);
                    end
                end
            end
        end
    end

    initial begin
        int p0;
        int k;
        rst_n = 1'b0;
        row_in = '0;
        row_valid = 1'b0;
        row_sync = 1'b0;
        blk_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_blk_valid", {31'b0, blk_valid}, 0);
        chk("rst_row_ready", {31'b0, row_ready}, 1);
        chk("rst_row_err", {31'b0, row_err}, 0);
        chk("rst_blk_out_zero", {31'b0, blk_out == '0}, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single block with the r*32+c pattern
        blk_ready = 1'b1;
        for (int r = 0; r < ROWS; r++) send_row(pat_row(r), r == 0, -1);
        @(negedge clk);
        #1;
        chk("single_valid", {31'b0, blk_valid}, 1);
        chk("single_byte0", {24'b0, blk_out[7:0]}, 32'h00);
        chk("single_byte1", {24'b0, blk_out[15:8]}, 32'h20);
        chk("single_top", {24'b0, blk_out[BLK_W-1 -: 8]}, 32'hFF);
        @(negedge clk);
        #1;
        chk("single_valid_drop", {31'b0, blk_valid}, 0);

        // Backpressure: two full banks stall intake
        @(negedge clk);
        blk_ready = 1'b0;
        for (int i = 0; i < 2*ROWS; i++) send_row(rnd_row(), (i % ROWS) == 0, -1);
        @(negedge clk);
        #1;
        chk("bp_ready_low", {31'b0, row_ready}, 0);
        chk("bp_valid", {31'b0, blk_valid}, 1);
        row_in = rnd_row();
        row_sync = 1'b1;
        row_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("bp_held", {31'b0, row_ready}, 0);
        end
        row_valid = 1'b0;
        @(negedge clk);
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        #1;
        chk("bp_ready_back", {31'b0, row_ready}, 1);
        chk("bp_valid_blk1", {31'b0, blk_valid}, 1);
        if (exp_q.size() != 0) chk_blk("bp_blk1", blk_out, exp_q[0]);
        else chk("bp_queue", 0, 1);
        @(negedge clk);
        blk_ready = 1'b1;
        @(negedge clk);

        // Resync after 3 rows, then the block restarting at the sync row
        p0 = err_pulses;
        for (int i = 0; i < 3; i++) send_row(rnd_row(), i == 0, -1);
        send_row({COLS{8'hAA}}, 1'b1, -1);
        for (int i = 0; i < ROWS - 2; i++) send_row(rnd_row(), 1'b0, -1);
        @(negedge clk);
        #1;
        chk("resync_not_yet", {31'b0, blk_valid}, 0);
        blk_ready = 1'b0;
        send_row(rnd_row(), 1'b0, -1);
        @(negedge clk);
        #1;
        chk("resync_valid", {31'b0, blk_valid}, 1);
        k = 1;
        for (int c = 0; c < COLS; c++) if (blk_out[c*ROWS*PIXEL +: PIXEL] !== 8'hAA) k = 0;
        chk("resync_row0_aa", k, 1);
        chk("resync_err_pulses", err_pulses - p0, 1);
        @(negedge clk);
        blk_ready = 1'b1;
        @(negedge clk);

        // Streaming: one row per cycle with blk_ready held high
        hs_cyc.delete();
        p0 = err_pulses;
        for (int i = 0; i < 8*ROWS; i++) send_row(rnd_row(), (i % ROWS) == 0, -1);
        repeat (3) @(negedge clk);
        chk("stream_blocks", hs_cyc.size(), 8);
        for (int i = 1; i < hs_cyc.size(); i++) chk("stream_spacing", hs_cyc[i] - hs_cyc[i-1], 8);
        chk("stream_no_err", err_pulses - p0, 0);

        // Completion of block B in the same cycle block A is released
        blk_ready = 1'b0;
        for (int i = 0; i < 2*ROWS - 1; i++) send_row(rnd_row(), (i % ROWS) == 0, -1);
        send_row(rnd_row(), 1'b0, 1);
        @(negedge clk);
        blk_ready = 1'b0;
        #1;
        chk("simul_valid", {31'b0, blk_valid}, 1);
        if (exp_q.size() != 0) chk_blk("simul_blkB", blk_out, exp_q[0]);
        else chk("simul_queue", 0, 1);
        @(negedge clk);
        blk_ready = 1'b1;
        @(negedge clk);

        // Asynchronous reset in the middle of a block
        for (int i = 0; i < 5; i++) send_row(rnd_row(), i == 0, -1);
        #2;
        rst_n = 1'b0;
        model_rows.delete();
        exp_q.delete();
        #1;
        chk("mid_rst_valid", {31'b0, blk_valid}, 0);
        chk("mid_rst_ready", {31'b0, row_ready}, 1);
        chk("mid_rst_err", {31'b0, row_err}, 0);
        chk("mid_rst_blk_zero", {31'b0, blk_out == '0}, 1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < ROWS; r++) send_row(pat_row(ROWS - 1 - r), r == 0, -1);
        repeat (2) @(negedge clk);

        // Randomized traffic: gaps, random blk_ready, occasional resyncs
        rand_rdy = 1;
        k = 0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_row(rnd_row(), (k % ROWS) == 0 || $urandom_range(0, 11) == 0, -1);
            k++;
        end
        rand_rdy = 0;
        @(negedge clk);
        blk_ready = 1'b1;
        for (int w = 0; w < 40 && exp_q.size() != 0; w++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
